// File: rtl/scanline_renderer.sv
// Tile-based background scanline renderer: fetches map/tile bytes from VRAM and streams
// palette-mapped pixels over a valid/ready handshake. Window layer built only with SCANLINE_WINDOW_EN.
module scanline_renderer #(
  parameter int LINE_WIDTH = 160,
  parameter int NUM_LINES  = 144,
  parameter int VRAM_AW    = 13
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          drawline,
  input  logic [7:0]                    lcdc,
  input  logic [7:0]                    scx,
  input  logic [7:0]                    scy,
  input  logic [7:0]                    wx,
  input  logic [7:0]                    wy,
  input  logic [7:0]                    bgp,
  output logic                          vram_rd,
  output logic [VRAM_AW-1:0]            vram_addr,
  input  logic [7:0]                    vram_data,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [1:0]                    pix_shade,
  output logic [$clog2(LINE_WIDTH)-1:0] pix_x,
  output logic [7:0]                    cur_line,
  output logic                          busy,
  output logic                          line_done,
  output logic                          frame_done
);
  localparam int XW = $clog2(LINE_WIDTH);

  typedef enum logic [2:0] {IDLE, MAP, LO, HI, PUSH} state_t;
  state_t w_next_state, r_state;

  logic [7:0]    r_lcdc, r_bgp, r_ybg, r_idx, r_lo, r_hi, r_cur_line;
  logic [4:0]    r_mcol;
  logic [2:0]    r_skip;
  logic [3:0]    r_bit;
  logic [1:0]    r_ph;
  logic          r_first, r_last, r_vram_rd, r_pix_valid, r_line_done, r_frame_done;
  logic [XW-1:0] r_col, r_pix_x;
  logic [1:0]    r_pix_shade;
  logic [VRAM_AW-1:0] r_vram_addr;

  logic w_xfer, w_can_load, w_line_end, w_refetch, w_emit, w_fetch_done, w_win_trig, w_map_hi;
  logic [4:0] w_mrow;
  logic [2:0] w_trow;
  logic [1:0] w_color, w_shade;
  logic [VRAM_AW-1:0] w_map_addr, w_tile_addr;

`ifdef SCANLINE_WINDOW_EN
  logic [7:0] r_wx, r_wy, r_wline;
  logic       r_in_win;
  assign w_win_trig = r_lcdc[5] & r_lcdc[0] & ~r_in_win & (r_cur_line >= r_wy) &
                      ((32'(r_col) + 32'd7) >= 32'(r_wx));
  assign w_mrow     = r_in_win ? r_wline[7:3] : r_ybg[7:3];
  assign w_trow     = r_in_win ? r_wline[2:0] : r_ybg[2:0];
  assign w_map_hi   = r_in_win ? r_lcdc[6] : r_lcdc[3];
`else
  assign w_win_trig = 1'b0;
  assign w_mrow     = r_ybg[7:3];
  assign w_trow     = r_ybg[2:0];
  assign w_map_hi   = r_lcdc[3];
`endif

  assign w_xfer       = r_pix_valid & pix_ready;
  assign w_can_load   = ~r_pix_valid | pix_ready;
  assign w_fetch_done = (r_ph == 2'd2);
  assign w_line_end   = (r_state == PUSH) & w_xfer & r_last;
  // Leave PUSH only once the output slot is empty after this edge, so no pixel is dropped.
  assign w_refetch    = (r_state == PUSH) & w_can_load & ~r_last & (w_win_trig | (r_lcdc[0] & r_bit[3]));
  assign w_emit       = (r_state == PUSH) & w_can_load & ~r_last & ~w_refetch;

  assign w_color     = {r_hi[7], r_lo[7]};
  assign w_shade     = r_bgp[{w_color, 1'b0} +: 2];
  assign w_map_addr  = VRAM_AW'(w_map_hi ? 16'h1C00 : 16'h1800) + VRAM_AW'({w_mrow, r_mcol});
  assign w_tile_addr = (r_lcdc[4] ? VRAM_AW'({r_idx, 4'd0})
                                  : VRAM_AW'(16'h1000) + VRAM_AW'({{4{r_idx[7]}}, r_idx, 4'd0}))
                       + VRAM_AW'({w_trow, 1'b0});

  assign vram_rd    = r_vram_rd;
  assign vram_addr  = r_vram_addr;
  assign pix_valid  = r_pix_valid;
  assign pix_shade  = r_pix_shade;
  assign pix_x      = r_pix_x;
  assign cur_line   = r_cur_line;
  assign busy       = (r_state != IDLE);
  assign line_done  = r_line_done;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (drawline) w_next_state = lcdc[0] ? MAP : PUSH;
      MAP:     if (w_fetch_done) w_next_state = LO;
      LO:      if (w_fetch_done) w_next_state = HI;
      HI:      if (w_fetch_done) w_next_state = PUSH;
      PUSH: begin
        if (w_line_end)     w_next_state = IDLE;
        else if (w_refetch) w_next_state = MAP;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lcdc <= '0; r_bgp <= '0; r_ybg <= '0; r_idx <= '0; r_lo <= '0; r_hi <= '0;
      r_cur_line <= '0; r_mcol <= '0; r_skip <= '0; r_bit <= '0; r_ph <= '0;
      r_first <= 1'b0; r_last <= 1'b0; r_vram_rd <= 1'b0; r_pix_valid <= 1'b0;
      r_line_done <= 1'b0; r_frame_done <= 1'b0; r_col <= '0; r_pix_x <= '0;
      r_pix_shade <= '0; r_vram_addr <= '0;
`ifdef SCANLINE_WINDOW_EN
      r_wx <= '0; r_wy <= '0; r_wline <= '0; r_in_win <= 1'b0;
`endif
    end else begin
      r_vram_rd    <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_ph <= '0;
          if (drawline) begin
            r_lcdc <= lcdc; r_bgp <= bgp; r_ybg <= r_cur_line + scy;
            r_mcol <= scx[7:3]; r_skip <= scx[2:0]; r_first <= 1'b1;
            r_col <= '0; r_last <= 1'b0; r_lo <= '0; r_hi <= '0; r_bit <= '0; r_pix_x <= '0;
`ifdef SCANLINE_WINDOW_EN
            r_wx <= wx; r_wy <= wy; r_in_win <= 1'b0;
`endif
          end
        end
        MAP, LO, HI: begin
          r_ph <= w_fetch_done ? 2'd0 : r_ph + 2'd1;
          if (r_ph == 2'd0) begin
            r_vram_rd <= 1'b1;
            if (r_state == MAP)     r_vram_addr <= w_map_addr;
            else if (r_state == LO) r_vram_addr <= w_tile_addr;
            else                    r_vram_addr <= w_tile_addr | VRAM_AW'(1);
          end
          if (w_fetch_done) begin
            if (r_state == MAP)     r_idx <= vram_data;
            else if (r_state == LO) r_lo <= vram_data;
            else begin
              // Pre-shift the first tile so its leading fine-scroll pixels are never emitted.
              r_hi    <= vram_data << (r_first ? r_skip : 3'd0);
              r_lo    <= r_lo << (r_first ? r_skip : 3'd0);
              r_bit   <= r_first ? {1'b0, r_skip} : 4'd0;
              r_first <= 1'b0;
              r_mcol  <= r_mcol + 5'd1;
            end
          end
        end
        PUSH: begin
          if (w_line_end) begin
            r_pix_valid <= 1'b0;
            r_line_done <= 1'b1;
            if (r_cur_line == 8'(NUM_LINES - 1)) begin
              r_cur_line   <= '0;
              r_frame_done <= 1'b1;
            end else begin
              r_cur_line <= r_cur_line + 8'd1;
            end
`ifdef SCANLINE_WINDOW_EN
            if (r_cur_line == 8'(NUM_LINES - 1)) r_wline <= '0;
            else if (r_in_win)                   r_wline <= r_wline + 8'd1;
`endif
          end else if (w_refetch) begin
            r_pix_valid <= 1'b0;
`ifdef SCANLINE_WINDOW_EN
            if (w_win_trig) begin
              r_in_win <= 1'b1;
              r_mcol   <= '0;
              r_first  <= 1'b1;
              r_skip   <= (r_wx < 8'd7) ? 3'(8'd7 - r_wx) : 3'd0;
            end
`endif
          end else if (w_emit) begin
            r_pix_valid <= 1'b1;
            r_pix_shade <= w_shade;
            r_pix_x     <= r_col;
            r_col       <= r_col + 1'b1;
            r_lo        <= r_lo << 1;
            r_hi        <= r_hi << 1;
            r_bit       <= r_bit + 4'd1;
            if (r_col == XW'(LINE_WIDTH - 1)) r_last <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_scanline_renderer.sv
// Scoreboard bench for scanline_renderer: a pixel-coordinate reference model queues the
// expected {x, shade} stream per line; the stream monitor pops and compares on each transfer.
module tb_scanline_renderer;
  localparam int LW = 160;
  localparam int NL = 144;

  logic       clk = 1'b0;
  logic       reset_n, drawline, pix_ready;
  logic [7:0] lcdc, scx, scy, wx, wy, bgp;
  logic       vram_rd, pix_valid, busy, line_done, frame_done;
  logic [12:0] vram_addr;
  logic [7:0] vram_data = 8'h00;
  logic [1:0] pix_shade;
  logic [7:0] pix_x, cur_line;
  logic [7:0] vram [0:8191];

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int m_line  = 0;
  int m_wline = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (vram_rd) vram_data <= vram[vram_addr];

  scanline_renderer #(.LINE_WIDTH(LW), .NUM_LINES(NL), .VRAM_AW(13)) dut (
    .clk(clk), .reset_n(reset_n), .drawline(drawline),
    .lcdc(lcdc), .scx(scx), .scy(scy), .wx(wx), .wy(wy), .bgp(bgp),
    .vram_rd(vram_rd), .vram_addr(vram_addr), .vram_data(vram_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_shade(pix_shade), .pix_x(pix_x),
    .cur_line(cur_line), .busy(busy), .line_done(line_done), .frame_done(frame_done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit win_drawn(input int line);
`ifdef SCANLINE_WINDOW_EN
    return lcdc[5] && lcdc[0] && line >= int'(wy) && int'(wx) <= LW + 6;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_shade(input int line, input int x);
    logic [7:0] idx, lo, hi;
    int px, py, base, taddr, b, color;
    if (!lcdc[0]) return int'(bgp[1:0]);
    px   = (x + int'(scx)) % 256;
    py   = (line + int'(scy)) % 256;
    base = lcdc[3] ? 'h1C00 : 'h1800;
`ifdef SCANLINE_WINDOW_EN
    if (lcdc[5] && line >= int'(wy) && x + 7 >= int'(wx)) begin
      px   = x + 7 - int'(wx);
      py   = m_wline;
      base = lcdc[6] ? 'h1C00 : 'h1800;
    end
`endif
    idx   = vram[base + 32 * (py / 8) + (px / 8) % 32];
    taddr = lcdc[4] ? 16 * int'(idx) : 'h1000 + 16 * int'($signed(idx));
    taddr = taddr + 2 * (py % 8);
    lo    = vram[taddr];
    hi    = vram[taddr + 1];
    b     = px % 8;
    color = 2 * int'(hi[7 - b]) + int'(lo[7 - b]);
    return int'((bgp >> (2 * color)) & 8'h03);
  endfunction

  task automatic run_line(input int stall_at, input bit rand_rdy, input bit scramble, output int rds);
    int xfers = 0, cyc = 0, stall_left = 0, last_xfer = 0, e;
    bit done = 1'b0, stalled = 1'b0, exp_fd, wd;
    logic [7:0] saved_scx, saved_bgp;
    rds = 0;
    check("cur_line_start", int'(cur_line), m_line);
    for (int x = 0; x < LW; x++) exp_q.push_back(x * 4 + model_shade(m_line, x));
    exp_fd = (m_line == NL - 1);
    wd = win_drawn(m_line);
    saved_scx = scx; saved_bgp = bgp;
    @(posedge clk); #1; drawline = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1; drawline = 1'b0;
    check("busy_in_line", int'(busy), 1);
    if (scramble) begin scx = ~saved_scx; bgp = ~saved_bgp; end
    while (!done && cyc < 4000) begin
      cyc++;
      drawline = (stall_at >= 0 && cyc == 30);
      if (stall_at >= 0 && !stalled && xfers == stall_at && pix_valid) begin
        stalled = 1'b1; stall_left = 5;
      end
      if (stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else begin
        pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      if (vram_rd) rds++;
      if (!pix_ready && stalled && exp_q.size() > 0) begin
        check("stall_valid", int'(pix_valid), 1);
        check("stall_pix", int'(pix_x) * 4 + int'(pix_shade), exp_q[0]);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) check("pix_overflow", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pix", int'(pix_x) * 4 + int'(pix_shade), e);
        end
        xfers++;
        last_xfer = cyc;
      end
      if (frame_done && !line_done) check("frame_done_alone", 1, 0);
      if (line_done) begin
        done = 1'b1;
        check("xfers", xfers, LW);
        check("line_done_latency", cyc - last_xfer, 1);
        check("frame_done", int'(frame_done), int'(exp_fd));
        check("busy_after", int'(busy), 0);
        m_line = exp_fd ? 0 : m_line + 1;
        check("cur_line_next", int'(cur_line), m_line);
      end
      if (!done) begin @(posedge clk); #1; end
    end
    drawline = 1'b0;
    if (!done) check("line_timeout", 0, 1);
    check("queue_empty", exp_q.size(), 0);
    exp_q.delete();
    if (exp_fd) m_wline = 0;
    else if (wd) m_wline++;
    scx = saved_scx; bgp = saved_bgp;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rds, ld_seen;
    reset_n = 1'b0; drawline = 1'b0; pix_ready = 1'b0;
    lcdc = 8'h91; scx = 8'd0; scy = 8'd0; wx = 8'd0; wy = 8'd0; bgp = 8'hE4;
    for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
    vram['h1800] = 8'd1;
    vram['h0010] = 8'hFF;
    vram['h0011] = 8'h00;
    #12;
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_vram_rd", int'(vram_rd), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_line_done", int'(line_done), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_pix_x", int'(pix_x), 0);
    check("rst_pix_shade", int'(pix_shade), 0);
    check("rst_vram_addr", int'(vram_addr), 0);
    check("rst_cur_line", int'(cur_line), 0);
    @(posedge clk); #1; reset_n = 1'b1;

    run_line(-1, 1'b0, 1'b0, rds);
    scx = 8'd3;
    run_line(-1, 1'b1, 1'b1, rds);
    scx = 8'd0;
    run_line(50, 1'b0, 1'b0, rds);
    lcdc = 8'h81; scx = 8'd250; scy = 8'd37;
    run_line(-1, 1'b1, 1'b0, rds);
    lcdc = 8'h99; scx = 8'd123; scy = 8'd200; bgp = 8'h1B;
    run_line(-1, 1'b0, 1'b0, rds);
    lcdc = 8'h90; bgp = 8'h03; scx = 8'd0; scy = 8'd0;
    run_line(-1, 1'b0, 1'b0, rds);
    check("bg_off_no_vram_rd", rds, 0);

    lcdc = 8'h91; bgp = 8'hE4;
    @(posedge clk); #1; drawline = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1; drawline = 1'b0;
    for (int i = 0; i < 500 && !pix_valid; i++) begin @(posedge clk); #1; end
    repeat (20) @(posedge clk);
    #3;
    check("pre_reset_valid", int'(pix_valid), 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", int'(pix_valid), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_vram_rd", int'(vram_rd), 0);
    repeat (2) @(posedge clk);
    #1; reset_n = 1'b1;
    ld_seen = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (line_done) ld_seen++; end
    check("abort_no_line_done", ld_seen, 0);
    check("abort_cur_line", int'(cur_line), 0);
    m_line = 0; m_wline = 0;
    run_line(-1, 1'b0, 1'b0, rds);

    lcdc = 8'h90; bgp = 8'h36;
    for (int l = 1; l < NL; l++) run_line(-1, 1'b0, 1'b0, rds);
    check("frame_wrap_cur_line", int'(cur_line), 0);

    lcdc = 8'hF1; wx = 8'd87; wy = 8'd0; scx = 8'd0; scy = 8'd0; bgp = 8'hE4;
    run_line(-1, 1'b0, 1'b0, rds);
    run_line(-1, 1'b1, 1'b0, rds);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
